bcd_stopwatch_counter: RTL and testbench

//  Parametrised BCD stopwatch time base: fractional-second digits, seconds (00-59) and minutes (00-59).
//  It counts up or down on a qualified tick and supports synchronous clear, parallel load and rollover/zero flags.
//  It sits between the tick prescaler and the 7-segment display mux.
//  It generalises the earlier fixed sub-second/second cascade.

---
 rtl/bcd_stopwatch_counter.sv | 156 +++++++++++++++
 tb/tb_bcd_stopwatch_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_counter.sv
// BCD stopwatch time base: fractional digits, seconds 00-59, minutes 00-59.
// Counts up/down on a qualified tick with clear, saturating load and wrap flags.
// Optional lap capture is built in when BCD_STOPWATCH_LAP_CAPTURE_EN is defined;
// otherwise lap is ignored and lap_val/lap_valid are tied to zero.
module bcd_stopwatch_counter #(
    parameter int unsigned FRAC_DIGITS  = 1,
    parameter bit          STOP_AT_ZERO = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      down,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*FRAC_DIGITS+13:0] load_val,
    output logic [4*FRAC_DIGITS-1:0]  frac,
    output logic [3:0]                sec_o,
    output logic [2:0]                sec_t,
    output logic [3:0]                min_o,
    output logic [2:0]                min_t,
    output logic                      rollover,
    output logic                      zero,
    output logic [4*FRAC_DIGITS+13:0] lap_val,
    output logic                      lap_valid,
    input  logic                      lap
);

    localparam int unsigned FW = 4 * FRAC_DIGITS;
    localparam int unsigned ND = FRAC_DIGITS + 4;
    localparam int unsigned SO = FRAC_DIGITS;
    localparam int unsigned ST = FRAC_DIGITS + 1;
    localparam int unsigned MO = FRAC_DIGITS + 2;
    localparam int unsigned MT = FRAC_DIGITS + 3;

    // Digit 0 is the LS fractional digit; tens digits keep bit 3 at zero.
    logic [ND-1:0][3:0] dig_q, dig_d;
    logic               rollover_q, rollover_d;
    logic               carry;
    logic [FW+13:0]     count_packed;

    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (idx == ST || idx == MT) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [3:0] sat_ones(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [3:0] sat_tens(input logic [2:0] v);
        return (v > 3'd5) ? 4'd5 : {1'b0, v};
    endfunction

    assign zero         = (dig_q == '0);
    assign count_packed = {dig_q[MT][2:0], dig_q[MO], dig_q[ST][2:0], dig_q[SO],
                           dig_q[FRAC_DIGITS-1:0]};

    assign frac     = dig_q[FRAC_DIGITS-1:0];
    assign sec_o    = dig_q[SO];
    assign sec_t    = dig_q[ST][2:0];
    assign min_o    = dig_q[MO];
    assign min_t    = dig_q[MT][2:0];
    assign rollover = rollover_q;

    // Next count: clear over load over enabled step; the final carry/borrow out
    // of the top digit is exactly the wrap condition that drives rollover.
    always_comb begin
        dig_d      = dig_q;
        rollover_d = 1'b0;
        carry      = 1'b0;
        if (clear) begin
            dig_d = '0;
        end else if (load) begin
            for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
                dig_d[i] = sat_ones(load_val[4*i +: 4]);
            end
            dig_d[SO] = sat_ones(load_val[FW +: 4]);
            dig_d[ST] = sat_tens(load_val[FW+4 +: 3]);
            dig_d[MO] = sat_ones(load_val[FW+7 +: 4]);
            dig_d[MT] = sat_tens(load_val[FW+11 +: 3]);
        end else if (enable && !(down && STOP_AT_ZERO && zero)) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < ND; i++) begin
                if (carry) begin
                    if (!down) begin
                        if (dig_q[i] == digit_max(i)) begin
                            dig_d[i] = '0;
                        end else begin
                            dig_d[i] = dig_q[i] + 4'd1;
                            carry    = 1'b0;
                        end
                    end else begin
                        if (dig_q[i] == '0) begin
                            dig_d[i] = digit_max(i);
                        end else begin
                            dig_d[i] = dig_q[i] - 4'd1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
            rollover_d = carry;
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_q      <= '0;
            rollover_q <= 1'b0;
        end else begin
            dig_q      <= dig_d;
            rollover_q <= rollover_d;
        end
    end

`ifdef BCD_STOPWATCH_LAP_CAPTURE_EN
    logic [FW+13:0] lap_val_q, lap_val_d;
    logic           lap_valid_q, lap_valid_d;
    logic           unused_tens_msb;

    assign unused_tens_msb = dig_q[ST][3] ^ dig_q[MT][3];
    assign lap_val         = lap_val_q;
    assign lap_valid       = lap_valid_q;

    // Lap captures the pre-step count; a coincident clear wins and empties it.
    always_comb begin
        lap_val_d   = lap_val_q;
        lap_valid_d = lap_valid_q;
        if (clear) begin
            lap_val_d   = '0;
            lap_valid_d = 1'b0;
        end else if (lap) begin
            lap_val_d   = count_packed;
            lap_valid_d = 1'b1;
        end
    end

    // Lap capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_val_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_val_q   <= lap_val_d;
            lap_valid_q <= lap_valid_d;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = dig_q[ST][3] ^ dig_q[MT][3] ^ lap ^ (^count_packed);
    assign lap_val       = '0;
    assign lap_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter: three instances (FRAC=1 hold-at-zero,
// FRAC=1 wrap-at-zero, FRAC=2 hold-at-zero) share stimulus. The reference
// keeps each count as a plain integer of fractional ticks and derives digits
// by division; lap expectations follow BCD_STOPWATCH_LAP_CAPTURE_EN.
module tb_bcd_stopwatch_counter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0, down = 1'b0, clear = 1'b0, load = 1'b0, lap = 1'b0;

    logic [2:0] r_mt = '0;
    logic [3:0] r_mo = '0;
    logic [2:0] r_st = '0;
    logic [3:0] r_so = '0, r_f0 = '0, r_f1 = '0;
    logic [17:0] lv_a;
    logic [21:0] lv_h;
    assign lv_a = {r_mt, r_mo, r_st, r_so, r_f0};
    assign lv_h = {r_mt, r_mo, r_st, r_so, r_f0, r_f1};

    always #5 clk = ~clk;

    logic [3:0] a_frac, a_so, a_mo, w_frac, w_so, w_mo, h_so, h_mo;
    logic [2:0] a_st, a_mt, w_st, w_mt, h_st, h_mt;
    logic [7:0] h_frac;
    logic a_roll, a_zero, a_lapok, w_roll, w_zero, w_lapok, h_roll, h_zero, h_lapok;
    logic [17:0] a_lapv, w_lapv;
    logic [21:0] h_lapv;

    bcd_stopwatch_counter #(.FRAC_DIGITS(1), .STOP_AT_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .down(down), .clear(clear),
        .load(load), .load_val(lv_a), .frac(a_frac), .sec_o(a_so), .sec_t(a_st),
        .min_o(a_mo), .min_t(a_mt), .rollover(a_roll), .zero(a_zero),
        .lap_val(a_lapv), .lap_valid(a_lapok), .lap(lap));

    bcd_stopwatch_counter #(.FRAC_DIGITS(1), .STOP_AT_ZERO(1'b0)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .down(down), .clear(clear),
        .load(load), .load_val(lv_a), .frac(w_frac), .sec_o(w_so), .sec_t(w_st),
        .min_o(w_mo), .min_t(w_mt), .rollover(w_roll), .zero(w_zero),
        .lap_val(w_lapv), .lap_valid(w_lapok), .lap(lap));

    bcd_stopwatch_counter #(.FRAC_DIGITS(2), .STOP_AT_ZERO(1'b1)) dut_h (
        .clk(clk), .reset(reset), .enable(enable), .down(down), .clear(clear),
        .load(load), .load_val(lv_h), .frac(h_frac), .sec_o(h_so), .sec_t(h_st),
        .min_o(h_mo), .min_t(h_mt), .rollover(h_roll), .zero(h_zero),
        .lap_val(h_lapv), .lap_valid(h_lapok), .lap(lap));

    logic [17:0] cnt_a, cnt_w;
    logic [21:0] cnt_h;
    assign cnt_a = {a_mt, a_mo, a_st, a_so, a_frac};
    assign cnt_w = {w_mt, w_mo, w_st, w_so, w_frac};
    assign cnt_h = {h_mt, h_mo, h_st, h_so, h_frac};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count held as total fractional ticks.
    int unsigned mv[3];
    int unsigned mlap[3];
    bit          mroll[3];
    bit          mlapok[3];

    function automatic int unsigned fd(input int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int unsigned pw(input int k);
        return (k == 2) ? 100 : 10;
    endfunction
    function automatic int unsigned modulus(input int k);
        return 3600 * pw(k);
    endfunction
    function automatic bit stopz(input int k);
        return k != 1;
    endfunction
    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int unsigned load_value(input int k);
        int unsigned mins = 10 * sat(32'(r_mt), 5) + sat(32'(r_mo), 9);
        int unsigned secs = 10 * sat(32'(r_st), 5) + sat(32'(r_so), 9);
        int unsigned f = (k == 2) ? 10 * sat(32'(r_f0), 9) + sat(32'(r_f1), 9)
                                  : sat(32'(r_f0), 9);
        return (mins * 60 + secs) * pw(k) + f;
    endfunction

    function automatic int unsigned next_v(input int k, input int unsigned v);
        if (clear) return 0;
        if (load) return load_value(k);
        if (!enable) return v;
        if (down) begin
            if (v == 0) return stopz(k) ? 0 : modulus(k) - 1;
            return v - 1;
        end
        return (v == modulus(k) - 1) ? 0 : v + 1;
    endfunction

    function automatic bit wraps(input int k, input int unsigned v);
        if (clear || load || !enable) return 1'b0;
        return down ? (v == 0 && !stopz(k)) : (v == modulus(k) - 1);
    endfunction

    function automatic logic [25:0] to_bcd(input int k, input int unsigned v);
        int unsigned f = v % pw(k);
        int unsigned s = v / pw(k);
        int unsigned sec = s % 60;
        int unsigned mins = s / 60;
        logic [25:0] r = '0;
        logic [13:0] hi;
        for (int d = 0; d < int'(fd(k)); d++) begin
            r[4*d +: 4] = 4'(f % 10);
            f = f / 10;
        end
        hi = {3'(mins / 10), 4'(mins % 10), 3'(sec / 10), 4'(sec % 10)};
        r = r | (26'(hi) << (4 * fd(k)));
        return r;
    endfunction

    function automatic logic [63:0] exp_vec(input int k);
        logic [25:0] lv = '0;
        logic lok = 1'b0;
`ifdef BCD_STOPWATCH_LAP_CAPTURE_EN
        lv  = to_bcd(k, mlap[k]);
        lok = mlapok[k];
`endif
        return {9'd0, to_bcd(k, mv[k]), mroll[k], (mv[k] == 0), lv, lok};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] <= 0; mroll[k] <= 1'b0; mlap[k] <= 0; mlapok[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mv[k]     <= next_v(k, mv[k]);
                mroll[k]  <= wraps(k, mv[k]);
                mlap[k]   <= clear ? 0 : (lap ? mv[k] : mlap[k]);
                mlapok[k] <= clear ? 1'b0 : (lap ? 1'b1 : mlapok[k]);
            end
        end
    end

    // Every-cycle comparison against the reference, away from the clock edge.
    bit run_cmp = 1'b0;
    int roll_a = 0;
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cycle_a", {9'd0, 8'd0, cnt_a, a_roll, a_zero, 8'd0, a_lapv, a_lapok}, exp_vec(0));
            check("cycle_w", {9'd0, 8'd0, cnt_w, w_roll, w_zero, 8'd0, w_lapv, w_lapok}, exp_vec(1));
            check("cycle_h", {9'd0, 4'd0, cnt_h, h_roll, h_zero, 4'd0, h_lapv, h_lapok}, exp_vec(2));
            if (a_roll) roll_a++;
        end
    end

    task automatic tick(input logic en, input logic dn, input logic clr, input logic ld,
                        input logic lp);
        enable = en; down = dn; clear = clr; load = ld; lap = lp;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] mt, input logic [3:0] mo, input logic [2:0] st,
                              input logic [3:0] so, input logic [3:0] f0, input logic [3:0] f1);
        r_mt = mt; r_mo = mo; r_st = st; r_so = so; r_f0 = f0; r_f1 = f1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int r0;
    logic [1:0] ops [8];

    initial begin
        #1 reset = 1'b1;
        run_cmp = 1'b1;
        @(posedge clk); #1;
        check("reset_count", 64'(cnt_a), 64'(0));
        check("reset_flags", 64'({a_zero, a_roll, a_lapok}), 64'(3'b100));
        @(negedge clk); #2 reset = 1'b0;

        // 600 tenths up from zero is exactly one minute, with no wrap.
        r0 = roll_a;
        repeat (600) tick(1, 0, 0, 0, 0);
        check("t1_count", 64'(cnt_a), 64'({3'd0, 4'd1, 3'd0, 4'd0, 4'd0}));
        check("t1_no_roll", 64'(roll_a - r0), 64'(0));

        // Up-wrap from the top value.
        set_fields(5, 9, 5, 9, 9, 9);
        tick(0, 0, 0, 1, 0);
        check("t2_loaded", 64'(cnt_a), 64'({3'd5, 4'd9, 3'd5, 4'd9, 4'd9}));
        tick(1, 0, 0, 0, 0);
        check("t2_wrap_a", 64'({cnt_a, a_roll, a_zero}), 64'({18'd0, 1'b1, 1'b1}));
        check("t2_wrap_h", 64'({cnt_h, h_roll}), 64'({22'd0, 1'b1}));
        tick(0, 0, 0, 0, 0);
        check("t2_pulse_end", 64'({a_roll, a_zero}), 64'(2'b01));

        // Down at zero: hold vs wrap.
        r0 = roll_a;
        repeat (5) tick(1, 1, 0, 0, 0);
        check("t3_hold", 64'(cnt_a), 64'(0));
        check("t3_wrap", 64'(cnt_w), 64'({3'd5, 4'd9, 3'd5, 4'd9, 4'd5}));
        tick(0, 0, 0, 0, 0);
        check("t3_no_roll", 64'(roll_a - r0), 64'(0));

        // Saturating load, then clear beats load and enable.
        set_fields(7, 9, 0, 12, 4'hA, 3);
        tick(0, 0, 0, 1, 0);
        check("t4_sat_h", 64'(cnt_h), 64'({3'd5, 4'd9, 3'd0, 4'd9, 8'h93}));
        check("t4_sat_a", 64'(cnt_a), 64'({3'd5, 4'd9, 3'd0, 4'd9, 4'd9}));
        tick(1, 0, 1, 1, 0);
        check("t4_clear", 64'({cnt_a, cnt_w, cnt_h}), 64'(0));

        // Mixed direction/enable vectors from 00:00.2 ({enable, down}).
        ops = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        set_fields(0, 0, 0, 0, 2, 5);
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) tick(ops[i][1], ops[i][0], 0, 0, 0);
        check("mix_a_zero", 64'(a_zero), 64'(1));
        check("mix_w", 64'(cnt_w), 64'({3'd5, 4'd9, 3'd5, 4'd9, 4'd8}));

        // Asynchronous reset between edges.
        tick(0, 0, 1, 0, 0);
        repeat (7) tick(1, 0, 0, 0, 0);
        check("t5_pre", 64'(cnt_a), 64'(7));
        @(negedge clk); #2 reset = 1'b1;
        #1;
        check("t5_async", 64'({cnt_a, a_zero, h_zero}), 64'({18'd0, 1'b1, 1'b1}));
        @(negedge clk); #2 reset = 1'b0;
        repeat (3) tick(1, 0, 0, 0, 0);
        check("t5_resume", 64'(cnt_a), 64'(3));

        // Lap capture of the pre-step count while counting.
        tick(0, 0, 1, 0, 0);
        repeat (123) tick(1, 0, 0, 0, 0);
        check("t6_pre", 64'(cnt_a), 64'({3'd0, 4'd0, 3'd1, 4'd2, 4'd3}));
        tick(1, 0, 0, 0, 1);
        check("t6_continues", 64'(cnt_a), 64'({3'd0, 4'd0, 3'd1, 4'd2, 4'd4}));
`ifdef BCD_STOPWATCH_LAP_CAPTURE_EN
        check("t6_lap", 64'({a_lapv, a_lapok}), 64'({3'd0, 4'd0, 3'd1, 4'd2, 4'd3, 1'b1}));
`else
        check("t6_lap_off", 64'({a_lapv, a_lapok}), 64'(0));
`endif
        repeat (5) tick(1, 0, 0, 0, 0);
        set_fields(1, 2, 3, 4, 5, 6);
        tick(0, 0, 0, 1, 1);
        tick(1, 0, 1, 0, 0);
        check("t6_clear", 64'({a_lapv, a_lapok, cnt_a}), 64'(0));
        repeat (4) tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 1);
        check("t6_clear_lap", 64'(a_lapok), 64'(0));
        repeat (2) tick(0, 0, 0, 0, 0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
